// File: rtl/round_key_sequencer.sv
// Round key sequencer: holds one expanded key set and streams its round keys
// one per enabled cycle, ascending for encryption or descending for decryption.
module round_key_sequencer #(
  parameter int NB_BYTE       = 8,
  parameter int N_BYTES_STATE = 16,
  parameter int N_ROUNDS      = 14
) (
  input  logic                                        i_clock,
  input  logic                                        i_reset,
  input  logic                                        i_valid,
  input  logic [N_BYTES_STATE*NB_BYTE*(N_ROUNDS+1)-1:0] i_round_key_vector,
  input  logic                                        i_key_ready,
  input  logic                                        i_start,
  input  logic                                        i_decrypt,
  output logic [N_BYTES_STATE*NB_BYTE-1:0]            o_round_key,
  output logic [3:0]                                  o_round_index,
  output logic                                        o_key_valid,
  output logic                                        o_last,
  output logic                                        o_busy,
  output logic                                        o_keys_loaded
);

  localparam int          KEY_W    = N_BYTES_STATE * NB_BYTE;
  localparam logic [3:0]  LAST_IDX = 4'(N_ROUNDS);

  typedef enum logic [1:0] {IDLE, READY, RUN} state_t;

  state_t            state, state_nxt;
  logic [KEY_W-1:0]  key_mem [0:N_ROUNDS];
  logic [KEY_W-1:0]  key_p1;
  logic [3:0]        index_p1;
  logic              vld_p1;
  logic              last_p1;
  logic              dec_p1;
  logic              loaded_p1;

  logic              load;
  logic              start_acc;
  logic              step;
  logic [3:0]        start_idx;
  logic [3:0]        step_idx;
  logic [3:0]        final_idx;

  // A load wins over a start; starts are only honoured while holding keys idle.
  assign load      = i_valid & i_key_ready;
  assign start_acc = i_valid & i_start & ~i_key_ready & (state == READY);
  assign step      = i_valid & ~i_key_ready & (state == RUN);

  assign start_idx = i_decrypt ? LAST_IDX : 4'd0;
  assign step_idx  = dec_p1 ? (index_p1 - 4'd1) : (index_p1 + 4'd1);
  assign final_idx = dec_p1 ? 4'd0 : LAST_IDX;

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: loads re-arm from anywhere, a stream ends after its last key.
  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = READY;
    end else begin
      case (state)
        READY:   if (start_acc) state_nxt = RUN;
        RUN:     if (step && last_p1) state_nxt = READY;
        default: state_nxt = state;
      endcase
    end
  end

  // Key storage and registered stream outputs; everything holds while i_valid is low.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k <= N_ROUNDS; k++) key_mem[k] <= '0;
      key_p1    <= '0;
      index_p1  <= 4'd0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      dec_p1    <= 1'b0;
      loaded_p1 <= 1'b0;
    end else if (load) begin
      for (int k = 0; k <= N_ROUNDS; k++)
        key_mem[k] <= i_round_key_vector[k*KEY_W +: KEY_W];
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      loaded_p1 <= 1'b1;
    end else if (start_acc) begin
      // N_ROUNDS >= 1, so the first key is never the final one.
      dec_p1   <= i_decrypt;
      index_p1 <= start_idx;
      key_p1   <= key_mem[start_idx];
      vld_p1   <= 1'b1;
      last_p1  <= 1'b0;
    end else if (step) begin
      if (last_p1) begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end else begin
        index_p1 <= step_idx;
        key_p1   <= key_mem[step_idx];
        vld_p1   <= 1'b1;
        last_p1  <= (step_idx == final_idx);
      end
    end
  end

  assign o_round_key   = key_p1;
  assign o_round_index = index_p1;
  assign o_key_valid   = vld_p1;
  assign o_last        = last_p1;
  assign o_busy        = (state == RUN);
  assign o_keys_loaded = loaded_p1;

endmodule

// File: tb/tb_round_key_sequencer.sv
// Directed bench for round_key_sequencer in its default configuration.
module tb_round_key_sequencer;

  logic           i_clock = 1'b0;
  logic           i_reset = 1'b1;
  logic           i_valid = 1'b0;
  logic [1919:0]  i_round_key_vector = '0;
  logic           i_key_ready = 1'b0;
  logic           i_start = 1'b0;
  logic           i_decrypt = 1'b0;
  logic [127:0]   o_round_key;
  logic [3:0]     o_round_index;
  logic           o_key_valid;
  logic           o_last;
  logic           o_busy;
  logic           o_keys_loaded;

  int nvec = 0;
  int nerr = 0;

  round_key_sequencer dut (
    .i_clock            (i_clock),
    .i_reset            (i_reset),
    .i_valid            (i_valid),
    .i_round_key_vector (i_round_key_vector),
    .i_key_ready        (i_key_ready),
    .i_start            (i_start),
    .i_decrypt          (i_decrypt),
    .o_round_key        (o_round_key),
    .o_round_index      (o_round_index),
    .o_key_valid        (o_key_valid),
    .o_last             (o_last),
    .o_busy             (o_busy),
    .o_keys_loaded      (o_keys_loaded)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [127:0] kval(input int b);
    logic [7:0] by;
    by = 8'(b);
    return {16{by}};
  endfunction

  function automatic logic [1919:0] mkvec(input int base);
    logic [1919:0] v;
    v = '0;
    for (int k = 0; k < 15; k++) v[k*128 +: 128] = kval(base + k);
    return v;
  endfunction

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic load_keys(input int base);
    i_round_key_vector = mkvec(base);
    i_key_ready = 1'b1;
    tick();
    i_key_ready = 1'b0;
  endtask

  task automatic start_stream(input logic dec);
    i_decrypt = dec;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_valid = 1'b1;
    i_reset = 1'b1;
    i_round_key_vector = mkvec(8'h55);
    i_key_ready = 1'b1;
    i_start = 1'b1;
    tick();
    tick();
    i_key_ready = 1'b0;
    i_start = 1'b0;
    nvec++; if (o_round_key !== 128'd0) begin nerr++; $display("FAIL rst_key got %h exp 0", o_round_key); end
    nvec++; if (o_round_index !== 4'd0) begin nerr++; $display("FAIL rst_index got %0d exp 0", o_round_index); end
    nvec++; if (o_key_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got %b exp 0", o_key_valid); end
    nvec++; if (o_last !== 1'b0) begin nerr++; $display("FAIL rst_last got %b exp 0", o_last); end
    nvec++; if (o_busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b exp 0", o_busy); end
    nvec++; if (o_keys_loaded !== 1'b0) begin nerr++; $display("FAIL rst_loaded got %b exp 0", o_keys_loaded); end
    i_reset = 1'b0;
  endtask

  task automatic test_start_no_keys();
    i_start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      nvec++; if (o_key_valid !== 1'b0 || o_busy !== 1'b0) begin nerr++; $display("FAIL nokey_start c=%0d got vld=%b busy=%b exp 0/0", c, o_key_valid, o_busy); end
    end
    i_start = 1'b0;
    nvec++; if (o_keys_loaded !== 1'b0) begin nerr++; $display("FAIL nokey_loaded got %b exp 0", o_keys_loaded); end
  endtask

  task automatic test_ascending();
    load_keys(8'h10);
    nvec++; if (o_keys_loaded !== 1'b1 || o_busy !== 1'b0 || o_key_valid !== 1'b0) begin nerr++; $display("FAIL asc_load got loaded=%b busy=%b vld=%b exp 1/0/0", o_keys_loaded, o_busy, o_key_valid); end
    start_stream(1'b0);
    for (int k = 0; k < 15; k++) begin
      // Starts raised mid-stream must be ignored.
      i_start = (k >= 3 && k <= 10);
      nvec++; if (o_key_valid !== 1'b1 || o_busy !== 1'b1) begin nerr++; $display("FAIL asc_vld k=%0d got vld=%b busy=%b exp 1/1", k, o_key_valid, o_busy); end
      nvec++; if (o_round_key !== kval(8'h10 + k)) begin nerr++; $display("FAIL asc_key k=%0d got %h exp %h", k, o_round_key, kval(8'h10 + k)); end
      nvec++; if (o_round_index !== 4'(k)) begin nerr++; $display("FAIL asc_index got %0d exp %0d", o_round_index, k); end
      nvec++; if (o_last !== (k == 14)) begin nerr++; $display("FAIL asc_last k=%0d got %b exp %b", k, o_last, (k == 14)); end
      tick();
    end
    i_start = 1'b0;
    nvec++; if (o_key_valid !== 1'b0 || o_last !== 1'b0 || o_busy !== 1'b0) begin nerr++; $display("FAIL asc_end got vld=%b last=%b busy=%b exp 0/0/0", o_key_valid, o_last, o_busy); end
  endtask

  task automatic test_back_to_back_descending();
    start_stream(1'b1);
    for (int k = 0; k < 15; k++) begin
      nvec++; if (o_key_valid !== 1'b1) begin nerr++; $display("FAIL dec_vld k=%0d got %b exp 1", k, o_key_valid); end
      nvec++; if (o_round_key !== kval(8'h1E - k)) begin nerr++; $display("FAIL dec_key k=%0d got %h exp %h", k, o_round_key, kval(8'h1E - k)); end
      nvec++; if (o_round_index !== 4'(14 - k)) begin nerr++; $display("FAIL dec_index got %0d exp %0d", o_round_index, 14 - k); end
      nvec++; if (o_last !== (k == 14)) begin nerr++; $display("FAIL dec_last k=%0d got %b exp %b", k, o_last, (k == 14)); end
      tick();
    end
    nvec++; if (o_key_valid !== 1'b0 || o_busy !== 1'b0 || o_keys_loaded !== 1'b1) begin nerr++; $display("FAIL dec_end got vld=%b busy=%b loaded=%b exp 0/0/1", o_key_valid, o_busy, o_keys_loaded); end
  endtask

  task automatic test_gaps();
    start_stream(1'b0);
    for (int k = 0; k < 15; k++) begin
      nvec++; if (o_key_valid !== 1'b1 || o_round_key !== kval(8'h10 + k) || o_round_index !== 4'(k)) begin nerr++; $display("FAIL gap_key k=%0d got vld=%b idx=%0d key=%h exp 1/%0d/%h", k, o_key_valid, o_round_index, o_round_key, k, kval(8'h10 + k)); end
      if (k % 2 == 1) begin
        i_valid = 1'b0;
        tick();
        tick();
        nvec++; if (o_key_valid !== 1'b1 || o_round_key !== kval(8'h10 + k) || o_round_index !== 4'(k) || o_busy !== 1'b1) begin nerr++; $display("FAIL gap_hold k=%0d got vld=%b idx=%0d key=%h exp 1/%0d/%h", k, o_key_valid, o_round_index, o_round_key, k, kval(8'h10 + k)); end
        i_valid = 1'b1;
      end
      tick();
    end
    nvec++; if (o_key_valid !== 1'b0 || o_busy !== 1'b0) begin nerr++; $display("FAIL gap_end got vld=%b busy=%b exp 0/0", o_key_valid, o_busy); end
  endtask

  task automatic test_load_start_precedence();
    i_round_key_vector = mkvec(8'h10);
    i_key_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_key_ready = 1'b0;
    i_start = 1'b0;
    tick();
    nvec++; if (o_key_valid !== 1'b0 || o_busy !== 1'b0 || o_keys_loaded !== 1'b1) begin nerr++; $display("FAIL prec got vld=%b busy=%b loaded=%b exp 0/0/1", o_key_valid, o_busy, o_keys_loaded); end
  endtask

  task automatic test_reload();
    start_stream(1'b0);
    for (int c = 0; c < 5; c++) tick();
    nvec++; if (o_round_index !== 4'd5) begin nerr++; $display("FAIL reload_pre got %0d exp 5", o_round_index); end
    load_keys(8'hA0);
    nvec++; if (o_key_valid !== 1'b0 || o_last !== 1'b0 || o_busy !== 1'b0 || o_keys_loaded !== 1'b1) begin nerr++; $display("FAIL reload_abort got vld=%b last=%b busy=%b loaded=%b exp 0/0/0/1", o_key_valid, o_last, o_busy, o_keys_loaded); end
    start_stream(1'b0);
    for (int k = 0; k < 15; k++) begin
      nvec++; if (o_key_valid !== 1'b1 || o_round_key !== kval(8'hA0 + k) || o_last !== (k == 14)) begin nerr++; $display("FAIL reload_key k=%0d got vld=%b key=%h last=%b exp 1/%h/%b", k, o_key_valid, o_round_key, o_last, kval(8'hA0 + k), (k == 14)); end
      tick();
    end
  endtask

  task automatic test_reset_mid_stream();
    start_stream(1'b0);
    for (int c = 0; c < 7; c++) tick();
    nvec++; if (o_round_index !== 4'd7 || o_round_key !== kval(8'hA7)) begin nerr++; $display("FAIL rmid_pre got idx=%0d key=%h exp 7/%h", o_round_index, o_round_key, kval(8'hA7)); end
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    nvec++; if (o_round_key !== 128'd0 || o_round_index !== 4'd0) begin nerr++; $display("FAIL rmid_data got idx=%0d key=%h exp 0/0", o_round_index, o_round_key); end
    nvec++; if (o_key_valid !== 1'b0 || o_last !== 1'b0 || o_busy !== 1'b0 || o_keys_loaded !== 1'b0) begin nerr++; $display("FAIL rmid_ctrl got vld=%b last=%b busy=%b loaded=%b exp 0/0/0/0", o_key_valid, o_last, o_busy, o_keys_loaded); end
    i_start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      nvec++; if (o_key_valid !== 1'b0 || o_busy !== 1'b0) begin nerr++; $display("FAIL rmid_start c=%0d got vld=%b busy=%b exp 0/0", c, o_key_valid, o_busy); end
    end
    i_start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_no_keys();
    test_ascending();
    test_back_to_back_descending();
    test_gaps();
    test_load_start_precedence();
    test_reload();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/round_key_sequencer.md
ROUND_KEY_SEQUENCER -- requirements
Module: round_key_sequencer

Interface
REQ-001 SHALL have parameter NB_BYTE, default 8, bits per byte.
REQ-002 SHALL have parameter N_BYTES_STATE, default 16, bytes per round key.
REQ-003 SHALL have parameter N_ROUNDS, default 14, cipher rounds; the vector holds N_ROUNDS+1 keys; supported range 1..15.
REQ-004 SHALL have port i_clock  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port i_reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port i_valid  input  1  clock enable; when low, all state and outputs hold.
REQ-007 SHALL have port i_round_key_vector  input  N_BYTES_STATE*NB_BYTE*(N_ROUNDS+1)  round keys, key k at slice [k*128 +: 128] for the default configuration.
REQ-008 SHALL have port i_key_ready  input  1  load strobe, the key scheduler's output-ready pulse.
REQ-009 SHALL have port i_start  input  1  request to stream one key set.
REQ-010 SHALL have port i_decrypt  input  1  stream order select, sampled with i_start: 0 ascending, 1 descending.
REQ-011 SHALL have port o_round_key  output  N_BYTES_STATE*NB_BYTE  current round key, registered.
REQ-012 SHALL have port o_round_index  output  4  index k of o_round_key, registered.
REQ-013 SHALL have port o_key_valid  output  1  o_round_key/o_round_index are valid this cycle.
REQ-014 SHALL have port o_last  output  1  the final key of the stream is presented.
REQ-015 SHALL have port o_busy  output  1  stream in progress (state RUN).
REQ-016 SHALL have port o_keys_loaded  output  1  a key set is held internally.

Function
REQ-017 SHALL implement the states IDLE (no keys), READY (keys held, not streaming), and RUN (streaming); all transitions are qualified by i_valid.
REQ-018 SHALL, on i_valid & i_key_ready, capture i_round_key_vector into an internal register, set o_keys_loaded=1, and enter READY from any state.
REQ-019 SHALL, on a load during RUN, abort the stream: o_key_valid=0, o_last=0, o_busy=0 from the next cycle.
REQ-020 SHALL, on i_valid & i_start in READY, latch i_decrypt and set the start index to 0 (encrypt) or N_ROUNDS (decrypt); the first key appears on the following cycle (latency 1) with o_key_valid=1 and o_busy=1.
REQ-021 SHALL, in RUN on each i_valid cycle, present key[index] and step the index by +1 (encrypt) or -1 (decrypt); the stream is exactly N_ROUNDS+1 valid-qualified cycles.
REQ-022 SHALL assert o_last together with o_key_valid for the final key only (index N_ROUNDS encrypt, 0 decrypt).
REQ-023 SHALL, on the i_valid cycle after o_last, return to READY with o_key_valid=0, o_last=0, o_busy=0; the stored keys are retained.
REQ-024 SHALL ignore i_start in IDLE and in RUN (no restart, no error).
REQ-025 SHALL give precedence to the load when i_key_ready and i_start coincide; the start is discarded.
REQ-026 SHALL accept i_start in the same cycle the state returns to READY only on a subsequent i_valid cycle, so there is a minimum of one idle cycle between streams.
REQ-027 SHALL, while i_valid=0 in RUN, hold the index, o_round_key, o_key_valid and o_last unchanged, so the same key is held over multiple clocks.
REQ-028 SHALL keep o_round_index within 0..N_ROUNDS with no wrap-around; the index never steps beyond the final key.

Reset
REQ-029 SHALL, on i_reset=1 at a clock edge (independent of i_valid), enter IDLE, clear the stored key register, and drive o_round_key=0, o_round_index=0, o_key_valid=0, o_last=0, o_busy=0, o_keys_loaded=0.
REQ-030 SHALL give reset precedence over load and start in the same cycle; reset in mid-stream terminates the stream with no further keys output.

Verification
REQ-031 SHALL verify the ascending stream: key k = sixteen bytes of 8'h10+k, pulse i_key_ready, then i_start with i_decrypt=0 -> o_round_key = 0x10..10, 0x11..11, ... 0x1E..1E on 15 consecutive cycles, o_round_index 0..14, o_last only with index 14.
REQ-032 SHALL verify the descending stream: same keys, i_decrypt=1 -> o_round_index 14..0, first key 0x1E..1E, o_last with 0x10..10; then o_busy=0, o_keys_loaded=1.
REQ-033 SHALL verify start with no keys loaded: i_start after reset -> o_key_valid stays 0 for 20 cycles, state IDLE.
REQ-034 SHALL verify reload during a stream: new vector (key k = 8'hA0+k bytes) loaded at index 5 -> o_key_valid=0 on the next cycle; the next start streams 0xA0.. keys.
REQ-035 SHALL verify the i_valid gaps: i_valid toggled 1,0,0,1 during RUN -> each key is held across the gaps, still 15 distinct valid-qualified keys in order.
REQ-036 SHALL verify reset mid-stream: i_reset at index 7 -> all outputs 0 the next cycle, o_keys_loaded=0, and a subsequent i_start is ignored.
